// File: rtl/inst_mem_responder_pkg.sv
// Shared types and helpers for the instruction-memory responder.
// State encoding, response codes and the byte-offset address check.
package inst_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int   WORD_BYTES = 4;
    localparam logic RESP_OK    = 1'b0;
    localparam logic RESP_ERR   = 1'b1;

    // An offset is bad if it is not word aligned or lies beyond the array.
    function automatic logic addr_err(input logic [31:0] off, input int addr_w);
        logic [31:0] hi;
        hi = off >> (addr_w + 2);
        return ((off % 32'(WORD_BYTES)) != 32'd0) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Request/response bus between the fetch unit (master) and the responder (slave).
// Both channels are valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; once raised, valid and its payload hold until then.
interface inst_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/inst_mem_responder_array.sv
// Single-port synchronous RAM, 2^ADDR_W x 32, registered read, no reset.
module inst_mem_responder_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch responder: accepts one request, waits WAIT_CYCLES, accesses
// the RAM and returns a word or an error with registered outputs.
module inst_mem_responder
    import inst_mem_responder_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_responder_if.slave  bus,
    output state_t               state
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    logic              req_ready_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [3:0]        wait_cnt;
    logic              issued;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    logic [31:0]       off;
    logic              dec_err;
    logic              accept;
    logic              ram_en;
    logic [31:0]       ram_rdata;

    assign off     = bus.req_addr - BASE_ADDR;
    assign dec_err = addr_err(off, ADDR_W);
    assign accept  = (state == IDLE) && bus.req_valid && req_ready_q;

    // ACCESS spends one cycle issuing the RAM operation and one collecting it.
    assign ram_en  = (state == ACCESS) && !issued && !err_q;

    inst_mem_responder_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= RESP_OK;
            wait_cnt     <= 4'd0;
            issued       <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= off[ADDR_W+1:2];
                        we_q        <= bus.req_we;
                        wdata_q     <= bus.req_wdata;
                        err_q       <= dec_err;
                        wait_cnt    <= 4'd0;
                        issued      <= 1'b0;
                        req_ready_q <= 1'b0;
                        state       <= (WAIT_LAST == 4'd0) ? ACCESS : WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    // Counter stops at WAIT_LAST, so it can never wrap.
                    if (wait_cnt + 4'd1 == WAIT_LAST) begin
                        wait_cnt <= WAIT_LAST;
                        state    <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    if (!issued) begin
                        issued <= 1'b1;
                    end else begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= err_q ? RESP_ERR : RESP_OK;
                        resp_rdata_q <= (err_q || we_q) ? 32'd0 : ram_rdata;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= RESP_OK;
                        req_ready_q  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Randomized bench for inst_mem_responder: two instances (WAIT_CYCLES 1 and 0)
// checked against a word-array model with an expected-data queue.
module tb_inst_mem_responder;
    import inst_mem_responder_pkg::*;

    // ---------------- clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inst_mem_responder_if bus_a ();
    inst_mem_responder_if bus_b ();
    state_t state_a;
    state_t state_b;

    inst_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a), .state(state_a)
    );
    inst_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0000)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b), .state(state_b)
    );

    // ---------------- scoreboard
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model_mem [2][256];
    int          wait_of [2] = '{1, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // ---------------- bus access helpers
    task automatic drive_req(input int sel, input logic v, input logic we,
                             input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = a; bus_a.req_wdata = d;
        end else begin
            bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = a; bus_b.req_wdata = d;
        end
    endtask

    task automatic drive_rr(input int sel, input logic r);
        if (sel == 0) bus_a.resp_ready = r;
        else          bus_b.resp_ready = r;
    endtask

    function automatic logic get_req_ready(input int sel);
        return (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
    endfunction
    function automatic logic get_resp_valid(input int sel);
        return (sel == 0) ? bus_a.resp_valid : bus_b.resp_valid;
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus_a.resp_rdata : bus_b.resp_rdata;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus_a.resp_err : bus_b.resp_err;
    endfunction

    // Reference decode: byte offset from base 0, 256 words of 4 bytes.
    function automatic logic model_err(input logic [31:0] addr);
        return (addr % 32'd4 != 32'd0) || (addr >= 32'd1024);
    endfunction

    // ---------------- driver: one full transaction, entered and left at a negedge
    task automatic do_txn(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall, output time acc_t);
        int          k;
        logic        exp_err;
        logic [31:0] exp_d;
        logic [31:0] hold_d;
        logic        hold_e;
        exp_err = model_err(addr);
        acc_t   = 0;
        drive_req(sel, 1'b1, we, addr, wdata);
        k = 0;
        while (!get_req_ready(sel) && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) begin
            check("accept_timeout", 32'd0, 32'd1);
            drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0);
            return;
        end
        @(posedge clk);
        acc_t = $time;
        exp_q.push_back((exp_err || we) ? 32'd0 : model_mem[sel][addr[9:2]]);
        if (we && !exp_err) model_mem[sel][addr[9:2]] = wdata;
        @(negedge clk);
        k = 0;
        while (!get_resp_valid(sel) && k < 50) begin
            check("busy_req_ready", {31'd0, get_req_ready(sel)}, 32'd0);
            drive_req(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            drive_rr(sel, 1'($urandom_range(0, 1)));
            @(negedge clk);
            k++;
        end
        drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_d = exp_q.pop_front();
        check("latency", k, wait_of[sel] + 2);
        if (k >= 50) return;
        check("resp_err", {31'd0, get_err(sel)}, {31'd0, exp_err});
        check("resp_rdata", get_rdata(sel), exp_d);
        hold_d = get_rdata(sel);
        hold_e = get_err(sel);
        for (int s = 0; s < stall; s++) begin
            drive_rr(sel, 1'b0);
            @(negedge clk);
            check("hold_valid", {31'd0, get_resp_valid(sel)}, 32'd1);
            check("hold_rdata", get_rdata(sel), hold_d);
            check("hold_err", {31'd0, get_err(sel)}, {31'd0, hold_e});
            check("hold_req_ready", {31'd0, get_req_ready(sel)}, 32'd0);
        end
        drive_rr(sel, 1'b1);
        @(negedge clk);
        drive_rr(sel, 1'b0);
        check("resp_drop", {31'd0, get_resp_valid(sel)}, 32'd0);
        check("idle_req_ready", {31'd0, get_req_ready(sel)}, 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0, 1:    return {22'd0, 8'($urandom), 2'b00};
            2:       return {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            3:       return 32'd1024 + {20'd0, 10'($urandom), 2'b00};
            default: return {$urandom} | 32'h8000_0000;
        endcase
    endfunction

    // ---------------- watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus
    initial begin
        time t0;
        time t1;
        time t2;
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive_rr(0, 1'b0);
        drive_rr(1, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'd0, bus_a.req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        check("rst_rdata", bus_a.resp_rdata, 32'd0);
        check("rst_err", {31'd0, bus_a.resp_err}, 32'd0);
        check("rst_state", {30'd0, state_a}, {30'd0, IDLE});
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
        check("post_rst_ready_b", {31'd0, bus_b.req_ready}, 32'd1);

        // Preload every word so later reads have defined contents.
        for (int i = 0; i < 256; i++) do_txn(0, 1'b1, 32'(i * 4), $urandom, 0, t0);
        for (int i = 0; i < 256; i++) do_txn(1, 1'b1, 32'(i * 4), $urandom, 0, t0);

        // Preload then fetch, with backpressure and error cases.
        do_txn(0, 1'b1, 32'h08, 32'hE3A0_1005, 0, t0);
        do_txn(0, 1'b0, 32'h08, 32'd0, 0, t0);
        do_txn(0, 1'b0, 32'h08, 32'd0, 5, t0);
        do_txn(0, 1'b0, 32'h0A, 32'd0, 0, t0);
        do_txn(0, 1'b0, 32'h08, 32'd0, 1, t0);
        do_txn(0, 1'b1, 32'h400, 32'hDEAD_BEEF, 0, t0);
        do_txn(0, 1'b0, 32'h000, 32'd0, 0, t0);
        do_txn(0, 1'b0, 32'h3FC, 32'd0, 0, t0);
        do_txn(0, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 2, t0);

        // Zero wait states, back-to-back reads.
        do_txn(1, 1'b0, 32'h00, 32'd0, 0, t0);
        do_txn(1, 1'b0, 32'h04, 32'd0, 0, t1);
        do_txn(1, 1'b0, 32'h08, 32'd0, 0, t2);
        check("b2b_gap_1", 32'(t1 - t0), 32'd40);
        check("b2b_gap_2", 32'(t2 - t1), 32'd40);

        // Reset while a write sits in WAIT.
        drive_req(0, 1'b1, 1'b1, 32'h10, 32'hA5A5_5A5A);
        @(posedge clk);
        @(negedge clk);
        drive_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("mid_wait_state", {30'd0, state_a}, {30'd0, WAIT});
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, bus_a.req_ready}, 32'd0);
        check("mid_rst_state", {30'd0, state_a}, {30'd0, IDLE});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {31'd0, bus_a.req_ready}, 32'd1);
        do_txn(0, 1'b0, 32'h10, 32'd0, 0, t0);

        // Random mix on both instances.
        for (int i = 0; i < 80; i++)
            do_txn(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(0, 3), t0);
        for (int i = 0; i < 40; i++)
            do_txn(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(0, 3), t0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the CPU's instruction-fetch port, plus a preload (write) path used by benches and a boot loader.
- Accepts one request at a time over a valid/ready handshake and returns a 32-bit word or an error over a second valid/ready channel.
- Programmable wait states emulate slow instruction memory.
- Sits between the fetch unit (initiator) and a word-addressed synchronous RAM.

Parameters:
- ADDR_W, 8, word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra cycles between accept and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address.
- req_we  in  1  1 = write (preload), 0 = read (fetch).
- req_wdata  in  32  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  misaligned or out-of-range access.

Behaviour:
- Reset values: req_ready=0 while rst is high, then 1 in the first cycle after release. resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE, wait counter=0. Memory contents are not reset.
- States:
  - IDLE: req_ready=1. On req_valid, latch addr/we/wdata and go to WAIT. If WAIT_CYCLES=0, go directly to ACCESS.
  - WAIT: req_ready=0. Counter counts 1..WAIT_CYCLES, then go to ACCESS.
  - ACCESS: issue the RAM operation (1-cycle synchronous read), then go to RESP.
  - RESP: resp_valid=1. When resp_ready=1, go to IDLE. resp_valid drops the next cycle.
- Latency from accept edge to resp_valid: WAIT_CYCLES+2 cycles. With WAIT_CYCLES=1, a request accepted at edge 0 gives resp_valid high after edge 3.
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake. At most one transaction is outstanding.
- Address decode: offset = req_addr - BASE_ADDR, computed 32-bit with wrap.
  - Misaligned (offset[1:0]≠0): error.
  - offset[31:ADDR_W+2]≠0: error.
  - Error: no RAM access, resp_err=1, resp_rdata=0. Latency is unchanged.
- Writes: RAM is written in ACCESS. Response has rdata=0 and err per decode. Out-of-range or misaligned writes do not modify memory.
- Response stability: resp_rdata and resp_err stay constant while resp_valid=1 and resp_ready=0. resp_valid never drops without a handshake.
- Request inputs are ignored outside IDLE. req_valid may drop without penalty while req_ready=0.
- resp_ready high while resp_valid=0 has no effect.
- Reset mid-transaction:
  - Transaction is abandoned and outputs return to reset values on the same edge (asynchronously).
  - A write already in ACCESS at the reset edge may or may not complete; benches must not depend on either outcome.
  - A write still in WAIT never reaches memory.
- Wait counter width is 4 bits and saturates at WAIT_CYCLES; no wrap.

Decomposition:
- Shared package (cpu_pkg):
  - State enum: IDLE, WAIT, ACCESS, RESP.
  - Constant WORD_BYTES=4.
  - Response encoding localparams: RESP_OK=0, RESP_ERR=1.
- Sub-module inst_mem_array:
  - Single-port synchronous RAM, 2^ADDR_W x 32.
  - Ports: clk, en, we, addr, wdata, rdata.
  - Registered read, no reset on the array.
- The responder holds the FSM, decode, wait counter and output registers.

Test Plan:
- Preload then fetch, WAIT_CYCLES=1: write 32'hE3A0_1005 to addr 0x08, then read 0x08 → resp_rdata=32'hE3A0_1005, resp_err=0, resp_valid exactly 3 cycles after read accept.
- Backpressure: read 0x08 with resp_ready held 0 for 5 cycles → resp_valid and resp_rdata stable for all 5 cycles, req_ready=0 throughout. Response completes on the first cycle with resp_ready=1.
- Misaligned read 0x0A → resp_err=1, rdata=0. A subsequent read of 0x08 still returns 32'hE3A0_1005.
- Out of range with ADDR_W=8: write 32'hDEAD_BEEF to 0x400 → resp_err=1. Read 0x000 afterwards is unchanged. Read 0x3FC is OK with err=0.
- WAIT_CYCLES=0 back-to-back: reads of 0x00, 0x04, 0x08 with resp_ready=1 → each response arrives 2 cycles after accept, with one IDLE cycle between transactions.
- Reset during WAIT: assert rst mid-WAIT of a write to 0x10 → resp_valid=0 immediately, req_ready=1 after release, read of 0x10 returns its prior value.
